uart_link_rx: RTL and testbench



---
 rtl/uart_link_rx_if.sv | 25 ++
 rtl/uart_link_rx.sv | 242 ++++++++++++++++++++++++
 tb/tb_uart_link_rx.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/uart_link_rx_if.sv
// Bundles the serial link wire and the decoded keeper-position outputs of uart_link_rx.
// The master side drives rx; the slave side (the receiver) drives the decoded results.
interface uart_link_rx_if;
    logic        rx;
    logic [11:0] keeper_pos;
    logic        connect_corrected;
    logic        frame_valid;
    logic        link_error;

    modport master (
        output rx,
        input  keeper_pos,
        input  connect_corrected,
        input  frame_valid,
        input  link_error
    );

    modport slave (
        input  rx,
        output keeper_pos,
        output connect_corrected,
        output frame_valid,
        output link_error
    );
endinterface

// File: rtl/uart_link_rx.sv
// Receives the opponent board's UART link, parses A5/P1/P0/C keeper frames and tracks link liveness.
// Define UART_PARITY_EN to receive an even parity bit between the data bits and the stop bit.
module uart_link_rx #(
    parameter int CLK_FREQ       = 65_000_000,
    parameter int BAUD           = 115_200,
    parameter int TIMEOUT_CYCLES = 6_500_000,
    parameter int GAP_BYTES      = 4
) (
    input  logic          clk,
    input  logic          rst,
    uart_link_rx_if.slave link
);

    localparam int CLKS_PER_BIT = CLK_FREQ / BAUD;
    localparam int HALF_BIT     = (CLKS_PER_BIT / 2 > 0) ? CLKS_PER_BIT / 2 : 1;
`ifdef UART_PARITY_EN
    localparam int BITS_PER_BYTE = 11;
`else
    localparam int BITS_PER_BYTE = 10;
`endif
    localparam int GAP_LIMIT = GAP_BYTES * BITS_PER_BYTE * CLKS_PER_BIT;
    localparam int CNT_W     = $clog2(CLKS_PER_BIT + 1);
    localparam int GAP_W     = $clog2(GAP_LIMIT + 1);
    localparam int WD_W      = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [2:0] RX_IDLE   = 3'd0;
    localparam logic [2:0] RX_START  = 3'd1;
    localparam logic [2:0] RX_DATA   = 3'd2;
    localparam logic [2:0] RX_STOP   = 3'd3;
`ifdef UART_PARITY_EN
    localparam logic [2:0] RX_PARITY = 3'd4;
`endif

    localparam logic [1:0] P_HUNT = 2'd0;
    localparam logic [1:0] P_HI   = 2'd1;
    localparam logic [1:0] P_LO   = 2'd2;
    localparam logic [1:0] P_CHK  = 2'd3;

    localparam logic [7:0] HEADER = 8'hA5;

    logic             rx_meta_q, rx_sync_q, rx_prev_q;
    logic [2:0]       rxs_q, rxs_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       idx_q, idx_d;
    logic [7:0]       shift_q, shift_d;
    logic             bv_q, bv_d;
    logic             fe_q, fe_d;
    logic             bit_done;

    logic [1:0]       pst_q, pst_d;
    logic [3:0]       p1_q, p1_d;
    logic [7:0]       p0_q, p0_d;
    logic [GAP_W-1:0] gap_q, gap_d;
    logic [WD_W-1:0]  wd_q, wd_d;
    logic [11:0]      keeper_q, keeper_d;
    logic             conn_q, conn_d;
    logic             fv_q, le_q;
    logic             accept, err;

    // Two-stage synchroniser plus one history stage for start-edge detection; idle line is high.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_meta_q <= 1'b1;
            rx_sync_q <= 1'b1;
            rx_prev_q <= 1'b1;
        end else begin
            rx_meta_q <= link.rx;
            rx_sync_q <= rx_meta_q;
            rx_prev_q <= rx_sync_q;
        end
    end

    assign bit_done = (cnt_q == CNT_W'(CLKS_PER_BIT - 1));

    always_comb begin
        rxs_d   = rxs_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        shift_d = shift_q;
        bv_d    = 1'b0;
        fe_d    = 1'b0;
        case (rxs_q)
            RX_IDLE: begin
                cnt_d = '0;
                idx_d = '0;
                if (rx_prev_q && !rx_sync_q) rxs_d = RX_START;
            end
            RX_START: begin
                if (cnt_q == CNT_W'(HALF_BIT - 1)) begin
                    cnt_d = '0;
                    rxs_d = rx_sync_q ? RX_IDLE : RX_DATA;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            RX_DATA: begin
                if (bit_done) begin
                    cnt_d   = '0;
                    shift_d = {rx_sync_q, shift_q[7:1]};
                    idx_d   = idx_q + 3'd1;
                    if (idx_q == 3'd7) begin
`ifdef UART_PARITY_EN
                        rxs_d = RX_PARITY;
`else
                        rxs_d = RX_STOP;
`endif
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
`ifdef UART_PARITY_EN
            RX_PARITY: begin
                if (bit_done) begin
                    cnt_d = '0;
                    if ((^shift_q) != rx_sync_q) begin
                        fe_d  = 1'b1;
                        rxs_d = RX_IDLE;
                    end else begin
                        rxs_d = RX_STOP;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
`endif
            RX_STOP: begin
                if (bit_done) begin
                    cnt_d = '0;
                    if (rx_sync_q) bv_d = 1'b1;
                    else           fe_d = 1'b1;
                    rxs_d = RX_IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: rxs_d = RX_IDLE;
        endcase
    end

    // Frame parser; a framing/parity error always wins over byte delivery and gap expiry.
    always_comb begin
        pst_d  = pst_q;
        p1_d   = p1_q;
        p0_d   = p0_q;
        accept = 1'b0;
        err    = 1'b0;
        if (fe_q) begin
            err   = 1'b1;
            pst_d = P_HUNT;
        end else if (bv_q) begin
            case (pst_q)
                P_HUNT: if (shift_q == HEADER) pst_d = P_HI;
                P_HI: begin
                    if (shift_q[7:4] != 4'd0) begin
                        err   = 1'b1;
                        pst_d = P_HUNT;
                    end else begin
                        p1_d  = shift_q[3:0];
                        pst_d = P_LO;
                    end
                end
                P_LO: begin
                    p0_d  = shift_q;
                    pst_d = P_CHK;
                end
                default: begin
                    if (shift_q == (HEADER ^ {4'd0, p1_q} ^ p0_q)) accept = 1'b1;
                    else                                           err    = 1'b1;
                    pst_d = P_HUNT;
                end
            endcase
        end else if (pst_q != P_HUNT && gap_q == GAP_W'(GAP_LIMIT)) begin
            pst_d = P_HUNT;
        end
    end

    always_comb begin
        gap_d = gap_q;
        if (pst_q == P_HUNT || bv_q)           gap_d = '0;
        else if (gap_q != GAP_W'(GAP_LIMIT))   gap_d = gap_q + GAP_W'(1);
    end

    // An accept clears the watchdog even on the cycle it would otherwise expire.
    always_comb begin
        wd_d     = wd_q;
        conn_d   = conn_q;
        keeper_d = keeper_q;
        if (accept) begin
            wd_d     = '0;
            conn_d   = 1'b1;
            keeper_d = {p1_q, p0_q};
        end else if (wd_q == WD_W'(TIMEOUT_CYCLES)) begin
            conn_d = 1'b0;
        end else begin
            wd_d = wd_q + WD_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rxs_q    <= RX_IDLE;
            cnt_q    <= '0;
            idx_q    <= '0;
            bv_q     <= 1'b0;
            fe_q     <= 1'b0;
            pst_q    <= P_HUNT;
            gap_q    <= '0;
            wd_q     <= '0;
            keeper_q <= '0;
            conn_q   <= 1'b0;
            fv_q     <= 1'b0;
            le_q     <= 1'b0;
        end else begin
            rxs_q    <= rxs_d;
            cnt_q    <= cnt_d;
            idx_q    <= idx_d;
            bv_q     <= bv_d;
            fe_q     <= fe_d;
            pst_q    <= pst_d;
            gap_q    <= gap_d;
            wd_q     <= wd_d;
            keeper_q <= keeper_d;
            conn_q   <= conn_d;
            fv_q     <= accept;
            le_q     <= err;
        end
    end

    // Payload registers are only read once the control path marks them valid.
    always_ff @(posedge clk) begin
        shift_q <= shift_d;
        p1_q    <= p1_d;
        p0_q    <= p0_d;
    end

    assign link.keeper_pos        = keeper_q;
    assign link.connect_corrected = conn_q;
    assign link.frame_valid       = fv_q;
    assign link.link_error        = le_q;

endmodule

// File: tb/tb_uart_link_rx.sv
// Directed bench for uart_link_rx at 10 clocks per bit; build with +define+UART_PARITY_EN for the parity case.
module tb_uart_link_rx;

    localparam int CLK_FREQ = 1_000_000;
    localparam int BAUD     = 100_000;
    localparam int CPB      = CLK_FREQ / BAUD;
    localparam int TIMEOUT  = 2000;
    localparam int GAPB     = 4;

    logic clk = 1'b0;
    logic rst;
    uart_link_rx_if link_if ();

    uart_link_rx #(
        .CLK_FREQ       (CLK_FREQ),
        .BAUD           (BAUD),
        .TIMEOUT_CYCLES (TIMEOUT),
        .GAP_BYTES      (GAPB)
    ) dut (
        .clk  (clk),
        .rst  (rst),
        .link (link_if)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;
    int fv_cnt = 0;
    int le_cnt = 0;
    int fv0, le0;

    always @(negedge clk) begin
        if (link_if.frame_valid) fv_cnt++;
        if (link_if.link_error)  le_cnt++;
    end

    task automatic chk(input string tag, input int got, input int exp);
        n_chk++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic snap();
        fv0 = fv_cnt;
        le0 = le_cnt;
    endtask

    task automatic idle(input int n);
        link_if.rx = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    task automatic send_bit(input logic b);
        link_if.rx = b;
        repeat (CPB) @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b, input logic flip_par);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(b[i]);
`ifdef UART_PARITY_EN
        send_bit((^b) ^ flip_par);
`else
        if (flip_par) link_if.rx = 1'b1;
`endif
        send_bit(1'b1);
    endtask

    task automatic send_frame(input logic [7:0] h, input logic [7:0] p1,
                              input logic [7:0] p0, input logic [7:0] c);
        send_byte(h, 1'b0);
        send_byte(p1, 1'b0);
        send_byte(p0, 1'b0);
        send_byte(c, 1'b0);
        idle(10);
    endtask

    initial begin
        rst        = 1'b1;
        link_if.rx = 1'b1;
        repeat (3) @(negedge clk);
        chk("reset_keeper", int'(link_if.keeper_pos), 0);
        chk("reset_conn", int'(link_if.connect_corrected), 0);
        chk("reset_fv", int'(link_if.frame_valid), 0);
        chk("reset_le", int'(link_if.link_error), 0);
        rst = 1'b0;
        idle(20);

        // Valid frame: checksum of A5 02 1C is A5^02^1C = BB.
        snap();
        send_frame(8'hA5, 8'h02, 8'h1C, 8'hBB);
        chk("ok_fv", fv_cnt - fv0, 1);
        chk("ok_le", le_cnt - le0, 0);
        chk("ok_keeper", int'(link_if.keeper_pos), 'h21C);
        chk("ok_conn", int'(link_if.connect_corrected), 1);

        snap();
        send_frame(8'hA5, 8'h02, 8'h1C, 8'hB8);
        chk("badsum_le", le_cnt - le0, 1);
        chk("badsum_fv", fv_cnt - fv0, 0);
        chk("badsum_keeper", int'(link_if.keeper_pos), 'h21C);

        snap();
        send_byte(8'hA5, 1'b0);
        send_byte(8'h12, 1'b0);
        idle(10);
        chk("nibble_le_at_p1", le_cnt - le0, 1);
        send_byte(8'h1C, 1'b0);
        send_byte(8'hA9, 1'b0);
        idle(10);
        chk("nibble_tail_silent", le_cnt - le0, 1);
        send_frame(8'hA5, 8'h00, 8'h64, 8'hC1);
        chk("nibble_next_fv", fv_cnt - fv0, 1);
        chk("nibble_next_keeper", int'(link_if.keeper_pos), 'h064);

        snap();
        send_frame(8'hA5, 8'h02, 8'h1C, 8'hBB);
        chk("wd_fv", fv_cnt - fv0, 1);
        idle(1930);
        chk("wd_conn_before", int'(link_if.connect_corrected), 1);
        idle(100);
        chk("wd_conn_after", int'(link_if.connect_corrected), 0);
        chk("wd_keeper_held", int'(link_if.keeper_pos), 'h21C);
        send_frame(8'hA5, 8'h00, 8'h64, 8'hC1);
        chk("wd_conn_restored", int'(link_if.connect_corrected), 1);
        chk("wd_keeper_new", int'(link_if.keeper_pos), 'h064);

        snap();
        send_byte(8'hA5, 1'b0);
        send_byte(8'h02, 1'b0);
        idle(450);
        send_byte(8'h1C, 1'b0);
        send_byte(8'hBB, 1'b0);
        idle(10);
        chk("gap_no_fv", fv_cnt - fv0, 0);
        chk("gap_no_le", le_cnt - le0, 0);
        chk("gap_keeper", int'(link_if.keeper_pos), 'h064);
        send_frame(8'hA5, 8'h02, 8'h1C, 8'hBB);
        chk("gap_next_fv", fv_cnt - fv0, 1);
        chk("gap_next_keeper", int'(link_if.keeper_pos), 'h21C);

        snap();
        send_byte(8'hA5, 1'b0);
        send_byte(8'h00, 1'b0);
        idle(250);
        send_byte(8'h64, 1'b0);
        send_byte(8'hC1, 1'b0);
        idle(10);
        chk("shortgap_fv", fv_cnt - fv0, 1);
        chk("shortgap_keeper", int'(link_if.keeper_pos), 'h064);

        snap();
        link_if.rx = 1'b0;
        repeat (300) @(negedge clk);
        idle(30);
        chk("break_le", le_cnt - le0, 1);
        chk("break_fv", fv_cnt - fv0, 0);
        send_frame(8'hA5, 8'h03, 8'hFF, 8'h59);
        chk("break_next_keeper", int'(link_if.keeper_pos), 'h3FF);
        chk("break_next_fv", fv_cnt - fv0, 1);

        send_byte(8'hA5, 1'b0);
        send_byte(8'h02, 1'b0);
        rst = 1'b1;
        #1;
        chk("arst_keeper", int'(link_if.keeper_pos), 0);
        chk("arst_conn", int'(link_if.connect_corrected), 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        idle(10);
        snap();
        send_byte(8'h1C, 1'b0);
        send_byte(8'hBB, 1'b0);
        idle(10);
        chk("arst_partial_fv", fv_cnt - fv0, 0);
        send_frame(8'hA5, 8'h00, 8'h64, 8'hC1);
        chk("arst_next_keeper", int'(link_if.keeper_pos), 'h064);
        chk("arst_next_conn", int'(link_if.connect_corrected), 1);

`ifdef UART_PARITY_EN
        snap();
        send_byte(8'hA5, 1'b1);
        idle(10);
        chk("par_le", le_cnt - le0, 1);
        send_frame(8'hA5, 8'h03, 8'hFF, 8'h59);
        chk("par_fv", fv_cnt - fv0, 1);
        chk("par_keeper", int'(link_if.keeper_pos), 'h3FF);
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
